reorder_buffer: RTL and testbench

//  Circular in-order reorder buffer between Dispatch, the execution units' common data bus (CDB) and the Regfile.

---
 rtl/reorder_buffer_pkg.sv | 19 +
 rtl/reorder_buffer.sv | 137 +++++++++++++
 tb/tb_reorder_buffer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared sizing constants and the entry record for the reorder buffer.
package reorder_buffer_pkg;

   localparam int unsigned ROB_DEPTH = 32;
   localparam int unsigned ROB_IDX_W = 5;
   localparam int unsigned DATA_W    = 32;

   typedef struct packed {
      logic              busy;
      logic              done;
      logic [4:0]        rd;
      logic              is_br;
      logic              is_st;
      logic              mispred;
      logic [DATA_W-1:0] value;
      logic [DATA_W-1:0] target;
   } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at tail, completes from the CDB,
// retires one entry per cycle at head and flushes on a committed mispredict.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 alloc_valid,
   input  logic [4:0]           alloc_rd,
   input  logic                 alloc_is_br,
   input  logic                 alloc_is_st,
   output logic [ROB_IDX_W-1:0] alloc_tag,
   output logic                 rob_full,
   input  logic                 cdb_valid,
   input  logic [ROB_IDX_W-1:0] cdb_tag,
   input  logic [DATA_W-1:0]    cdb_value,
   input  logic                 cdb_mispred,
   input  logic [DATA_W-1:0]    cdb_target,
   input  logic [ROB_IDX_W-1:0] q1_tag,
   input  logic [ROB_IDX_W-1:0] q2_tag,
   output logic                 q1_ready,
   output logic                 q2_ready,
   output logic [DATA_W-1:0]    q1_value,
   output logic [DATA_W-1:0]    q2_value,
   output logic                 commit_valid,
   output logic [4:0]           commit_rd,
   output logic [ROB_IDX_W-1:0] commit_tag,
   output logic [DATA_W-1:0]    commit_value,
   output logic                 commit_st,
   output logic                 clr,
   output logic [DATA_W-1:0]    clr_pc
);

   localparam logic [ROB_IDX_W-1:0] IDX_ONE  = ROB_IDX_W'(1);
   localparam logic [ROB_IDX_W:0]   CNT_ONE  = (ROB_IDX_W+1)'(1);
   localparam logic [ROB_IDX_W:0]   CNT_FULL = (ROB_IDX_W+1)'(ROB_DEPTH);

   rob_entry_t           ent [ROB_DEPTH];
   logic [ROB_IDX_W-1:0] head;
   logic [ROB_IDX_W-1:0] tail;
   logic [ROB_IDX_W:0]   count;

   logic do_alloc;
   logic do_commit;
   logic flush;

   always_comb begin
      rob_full  = (count == CNT_FULL);
      alloc_tag = tail;
      do_alloc  = alloc_valid && !rob_full;
      do_commit = (count != '0) && ent[head].done;
      flush     = do_commit && ent[head].mispred;
   end

   // Same-cycle CDB hit takes precedence over stored entry state
   always_comb begin
      q1_ready = ent[q1_tag].done;
      q1_value = ent[q1_tag].value;
      if (cdb_valid && (cdb_tag == q1_tag)) begin
         q1_ready = 1'b1;
         q1_value = cdb_value;
      end
      q2_ready = ent[q2_tag].done;
      q2_value = ent[q2_tag].value;
      if (cdb_valid && (cdb_tag == q2_tag)) begin
         q2_ready = 1'b1;
         q2_value = cdb_value;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         commit_valid <= 1'b0;
         commit_rd    <= '0;
         commit_tag   <= '0;
         commit_value <= '0;
         commit_st    <= 1'b0;
         clr          <= 1'b0;
         clr_pc       <= '0;
         for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
            ent[i] <= '0;
         end
      end else if (rdy) begin
         commit_valid <= do_commit;
         commit_st    <= do_commit && ent[head].is_st;
         clr          <= flush;
         if (do_commit) begin
            commit_rd    <= ent[head].rd;
            commit_tag   <= head;
            commit_value <= ent[head].value;
         end
         if (flush) begin
            clr_pc <= ent[head].target;
         end

         if (cdb_valid && ent[cdb_tag].busy) begin
            ent[cdb_tag].done    <= 1'b1;
            ent[cdb_tag].value   <= cdb_value;
            ent[cdb_tag].mispred <= cdb_mispred && ent[cdb_tag].is_br;
            ent[cdb_tag].target  <= cdb_target;
         end

         // Flush is last so it overrides any writeback or allocation this edge
         if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
               ent[i].busy <= 1'b0;
               ent[i].done <= 1'b0;
            end
         end else begin
            if (do_alloc) begin
               ent[tail] <= '{busy: 1'b1, done: 1'b0, rd: alloc_rd,
                              is_br: alloc_is_br, is_st: alloc_is_st,
                              mispred: 1'b0, value: '0, target: '0};
               tail      <= tail + IDX_ONE;
            end
            if (do_commit) begin
               ent[head].busy <= 1'b0;
               ent[head].done <= 1'b0;
               head           <= head + IDX_ONE;
            end
            case ({do_alloc, do_commit})
               2'b10:   count <= count + CNT_ONE;
               2'b01:   count <= count - CNT_ONE;
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a reference model and commit scoreboard.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 rdy = 1'b1;
   logic                 alloc_valid = 1'b0;
   logic [4:0]           alloc_rd = '0;
   logic                 alloc_is_br = 1'b0;
   logic                 alloc_is_st = 1'b0;
   logic [ROB_IDX_W-1:0] alloc_tag;
   logic                 rob_full;
   logic                 cdb_valid = 1'b0;
   logic [ROB_IDX_W-1:0] cdb_tag = '0;
   logic [DATA_W-1:0]    cdb_value = '0;
   logic                 cdb_mispred = 1'b0;
   logic [DATA_W-1:0]    cdb_target = '0;
   logic [ROB_IDX_W-1:0] q1_tag = '0;
   logic [ROB_IDX_W-1:0] q2_tag = '0;
   logic                 q1_ready, q2_ready;
   logic [DATA_W-1:0]    q1_value, q2_value;
   logic                 commit_valid;
   logic [4:0]           commit_rd;
   logic [ROB_IDX_W-1:0] commit_tag;
   logic [DATA_W-1:0]    commit_value;
   logic                 commit_st;
   logic                 clr;
   logic [DATA_W-1:0]    clr_pc;

   reorder_buffer dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_is_br(alloc_is_br),
      .alloc_is_st(alloc_is_st), .alloc_tag(alloc_tag), .rob_full(rob_full),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .cdb_mispred(cdb_mispred), .cdb_target(cdb_target),
      .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
      .q1_value(q1_value), .q2_value(q2_value),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
      .commit_value(commit_value), .commit_st(commit_st),
      .clr(clr), .clr_pc(clr_pc)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state: allocation-order queue of tags is the commit scoreboard
   int          tq[$];
   int          mtail;
   bit          m_busy [ROB_DEPTH];
   bit          m_done [ROB_DEPTH];
   bit          m_mis  [ROB_DEPTH];
   bit          m_st   [ROB_DEPTH];
   logic [4:0]  m_rd   [ROB_DEPTH];
   logic [31:0] m_val  [ROB_DEPTH];
   logic [31:0] m_tgt  [ROB_DEPTH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      tq.delete();
      mtail = 0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
         m_busy[i] = 1'b0;
         m_done[i] = 1'b0;
      end
   endtask

   task automatic tick();
      bit          exp_c, exp_mis, pre_full;
      int          h;
      logic [31:0] hold_cv, hold_ct, hold_cval;
      exp_c = 1'b0; exp_mis = 1'b0; h = 0;
      if (tq.size() > 0) begin
         h       = tq[0];
         exp_c   = m_done[h];
         exp_mis = m_done[h] && m_mis[h];
      end
      pre_full  = (tq.size() == ROB_DEPTH);
      hold_cv   = 32'(commit_valid);
      hold_ct   = 32'(commit_tag);
      hold_cval = commit_value;
      @(posedge clk);
      #1;
      if (rst) begin
         model_clear();
         chk("rst_commit_valid", 32'(commit_valid), 32'd0);
         chk("rst_clr", 32'(clr), 32'd0);
         chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
         chk("rst_full", 32'(rob_full), 32'd0);
      end else if (!rdy) begin
         chk("hold_commit_valid", 32'(commit_valid), hold_cv);
         chk("hold_commit_tag", 32'(commit_tag), hold_ct);
         chk("hold_commit_value", commit_value, hold_cval);
         chk("hold_alloc_tag", 32'(alloc_tag), 32'(mtail));
      end else begin
         chk("commit_valid", 32'(commit_valid), 32'(exp_c));
         chk("clr", 32'(clr), 32'(exp_mis));
         if (cdb_valid && m_busy[cdb_tag]) begin
            m_done[cdb_tag] = 1'b1;
            m_val[cdb_tag]  = cdb_value;
            m_mis[cdb_tag]  = cdb_mispred;
            m_tgt[cdb_tag]  = cdb_target;
         end
         if (exp_c) begin
            chk("commit_tag", 32'(commit_tag), 32'(h));
            chk("commit_rd", 32'(commit_rd), 32'(m_rd[h]));
            chk("commit_value", commit_value, m_val[h]);
            chk("commit_st", 32'(commit_st), 32'(m_st[h]));
            void'(tq.pop_front());
            m_busy[h] = 1'b0;
            m_done[h] = 1'b0;
         end else begin
            chk("commit_st_idle", 32'(commit_st), 32'd0);
         end
         if (exp_mis) begin
            chk("clr_pc", clr_pc, m_tgt[h]);
            model_clear();
         end else if (alloc_valid && !pre_full) begin
            tq.push_back(mtail);
            m_busy[mtail] = 1'b1;
            m_done[mtail] = 1'b0;
            m_mis[mtail]  = 1'b0;
            m_rd[mtail]   = alloc_rd;
            m_st[mtail]   = alloc_is_st;
            mtail = (mtail + 1) % ROB_DEPTH;
         end
         chk("alloc_tag", 32'(alloc_tag), 32'(mtail));
         chk("rob_full", 32'(rob_full), 32'(tq.size() == ROB_DEPTH));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic alloc(input logic [4:0] rd, input logic br, input logic st);
      alloc_valid = 1'b1; alloc_rd = rd; alloc_is_br = br; alloc_is_st = st;
      tick();
      alloc_valid = 1'b0; alloc_is_br = 1'b0; alloc_is_st = 1'b0;
   endtask

   task automatic wb(input int tag, input logic [31:0] val, input logic mis, input logic [31:0] tgt);
      cdb_valid = 1'b1; cdb_tag = ROB_IDX_W'(tag); cdb_value = val;
      cdb_mispred = mis; cdb_target = tgt;
      tick();
      cdb_valid = 1'b0; cdb_mispred = 1'b0;
   endtask

   initial begin
      model_clear();
      do_reset();

      // In-order commit despite out-of-order completion
      alloc(5'd5, 1'b0, 1'b0);
      alloc(5'd6, 1'b0, 1'b1);
      wb(1, 32'h22, 1'b0, 32'h0);
      wb(0, 32'h11, 1'b0, 32'h0);
      tick();
      tick();
      tick();

      // Operand query with same-cycle CDB bypass
      alloc(5'd7, 1'b0, 1'b0);
      alloc(5'd8, 1'b0, 1'b0);
      cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_value = 32'hABCD;
      q1_tag = 5'd3; q2_tag = 5'd2;
      #1;
      chk("q1_ready_bypass", 32'(q1_ready), 32'd1);
      chk("q1_value_bypass", q1_value, 32'hABCD);
      chk("q2_ready_pending", 32'(q2_ready), 32'd0);
      tick();
      cdb_valid = 1'b0;
      #1;
      chk("q1_ready_stored", 32'(q1_ready), 32'd1);
      chk("q1_value_stored", q1_value, 32'hABCD);
      wb(2, 32'h33, 1'b0, 32'h0);
      tick();
      tick();
      tick();

      // Fill to capacity, tail wraps to 0, extra alloc is dropped
      do_reset();
      for (int i = 0; i < ROB_DEPTH; i++) alloc(5'(i), 1'b0, 1'(i % 3 == 0));
      alloc(5'd1, 1'b0, 1'b0);
      wb(0, 32'h77, 1'b0, 32'h0);
      tick();
      alloc(5'd3, 1'b0, 1'b0);

      // Stall with rdy low just after a commit, then resume
      wb(1, 32'hA1, 1'b0, 32'h0);
      wb(2, 32'hA2, 1'b0, 32'h0);
      rdy = 1'b0;
      repeat (3) tick();
      rdy = 1'b1;
      tick();
      tick();

      // Branch at head mispredicts: flush, redirect, same-edge alloc dropped
      do_reset();
      alloc(5'd9, 1'b1, 1'b0);
      alloc(5'd10, 1'b0, 1'b0);
      wb(1, 32'h5, 1'b0, 32'h0);
      wb(0, 32'h44, 1'b1, 32'h100);
      alloc(5'd11, 1'b0, 1'b0);
      chk("flush_alloc_tag", 32'(alloc_tag), 32'd0);
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
